// File: rtl/hack_cpu_mc_if.sv
// Instruction-fetch and data-memory request/ack bus of the multi-cycle Hack CPU.
// The CPU is the master. Memories respond with an ack after any latency.
interface hack_cpu_mc_if #(
  parameter int DW = 16,
  parameter int AW = 15
);
  logic          imem_req;
  logic [AW-1:0] imem_addr;
  logic [DW-1:0] imem_rdata;
  logic          imem_ack;
  logic          dmem_req;
  logic          dmem_we;
  logic [AW-1:0] dmem_addr;
  logic [DW-1:0] dmem_wdata;
  logic [DW-1:0] dmem_rdata;
  logic          dmem_ack;

  modport master (
    output imem_req, imem_addr,
    input  imem_rdata, imem_ack,
    output dmem_req, dmem_we, dmem_addr, dmem_wdata,
    input  dmem_rdata, dmem_ack
  );

  modport slave (
    input  imem_req, imem_addr,
    output imem_rdata, imem_ack,
    input  dmem_req, dmem_we, dmem_addr, dmem_wdata,
    output dmem_rdata, dmem_ack
  );
endinterface

// File: rtl/hack_cpu_mc.sv
// Multi-cycle Hack CPU. It steps through FETCH/DECODE/MEMRD/EXEC/MEMWR and ends in HALT.
// Requests are decoded from the state. An ack in the same cycle as its request, or any later cycle, completes the access.
module hack_cpu_mc #(
  parameter int DW = 16,
  parameter int AW = 15
) (
  input  logic          clk,
  input  logic          reset,
  hack_cpu_mc_if.master bus,
  output logic [AW-1:0] pc,
  output logic          retired,
  output logic          halted
);

  typedef enum logic [2:0] {
    S_FETCH, S_DECODE, S_MEMRD, S_EXEC, S_MEMWR, S_HALT
  } state_t;

  state_t        state, state_nxt;
  logic [DW-1:0] a_reg, d_reg, ir, m_reg, wdata_reg;
  logic [AW-1:0] pc_reg;
  logic          prev_a, retired_reg;
  logic          a_commit, c_commit;

  logic [DW-1:0] y_sel, x_z, x_n, y_z, y_n, f_out, alu_out;
  logic          zr, ng, jump, halt_hit;
  logic [AW-1:0] target, pc_inc, pc_dec;

  // The ALU inputs (D, M, A, IR) stay stable from EXEC through MEMWR.
  // So the same combinational result can also drive the commit after a write.
  always_comb begin
    y_sel   = ir[12] ? m_reg : a_reg;
    x_z     = ir[11] ? '0 : d_reg;
    x_n     = ir[10] ? ~x_z : x_z;
    y_z     = ir[9]  ? '0 : y_sel;
    y_n     = ir[8]  ? ~y_z : y_z;
    f_out   = ir[7]  ? (x_n + y_n) : (x_n & y_n);
    alu_out = ir[6]  ? ~f_out : f_out;
  end

  assign zr       = (alu_out == '0);
  assign ng       = alu_out[DW-1];
  assign jump     = (ir[2] & ng) | (ir[1] & zr) | (ir[0] & ~ng & ~zr);
  assign target   = a_reg[AW-1:0];
  assign pc_inc   = pc_reg + AW'(1);
  assign pc_dec   = pc_reg - AW'(1);
  assign halt_hit = jump && ((target == pc_reg) || ((target == pc_dec) && prev_a));

  always_comb begin
    state_nxt = state;
    a_commit  = 1'b0;
    c_commit  = 1'b0;
    case (state)
      S_FETCH:  if (bus.imem_ack) state_nxt = S_DECODE;
      S_DECODE: begin
        if (!ir[DW-1]) begin
          a_commit  = 1'b1;
          state_nxt = S_FETCH;
        end else if (ir[12]) begin
          state_nxt = S_MEMRD;
        end else begin
          state_nxt = S_EXEC;
        end
      end
      S_MEMRD:  if (bus.dmem_ack) state_nxt = S_EXEC;
      S_EXEC: begin
        if (ir[3]) begin
          state_nxt = S_MEMWR;
        end else begin
          c_commit  = 1'b1;
          state_nxt = halt_hit ? S_HALT : S_FETCH;
        end
      end
      S_MEMWR: begin
        if (bus.dmem_ack) begin
          c_commit  = 1'b1;
          state_nxt = halt_hit ? S_HALT : S_FETCH;
        end
      end
      S_HALT:   state_nxt = S_HALT;
      default:  state_nxt = S_FETCH;
    endcase
  end

  // Requests are forced low while reset is held, so the reset cycle never handshakes.
  assign bus.imem_req   = (state == S_FETCH) && !reset;
  assign bus.imem_addr  = pc_reg;
  assign bus.dmem_req   = ((state == S_MEMRD) || (state == S_MEMWR)) && !reset;
  assign bus.dmem_we    = (state == S_MEMWR);
  assign bus.dmem_addr  = a_reg[AW-1:0];
  assign bus.dmem_wdata = wdata_reg;

  assign pc      = pc_reg;
  assign retired = retired_reg && !reset;
  assign halted  = (state == S_HALT) && !reset;

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= S_FETCH;
      a_reg       <= '0;
      d_reg       <= '0;
      ir          <= '0;
      m_reg       <= '0;
      wdata_reg   <= '0;
      pc_reg      <= '0;
      prev_a      <= 1'b0;
      retired_reg <= 1'b0;
    end else begin
      state       <= state_nxt;
      retired_reg <= a_commit | c_commit;
      if (state == S_FETCH && bus.imem_ack) ir <= bus.imem_rdata;
      if (state == S_MEMRD && bus.dmem_ack) m_reg <= bus.dmem_rdata;
      if (state == S_EXEC && ir[3]) wdata_reg <= alu_out;
      if (a_commit) begin
        a_reg  <= ir;
        pc_reg <= pc_inc;
        prev_a <= 1'b1;
      end
      if (c_commit) begin
        if (ir[5]) a_reg <= alu_out;
        if (ir[4]) d_reg <= alu_out;
        pc_reg <= jump ? target : pc_inc;
        prev_a <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_hack_cpu_mc.sv
// Bench for hack_cpu_mc: directed programs plus random programs with random ack latency.
// An instruction-level Hack interpreter produces the expected state after each retired instruction.
module tb_hack_cpu_mc;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic reset, reset2;
  hack_cpu_mc_if #(.DW(16), .AW(15)) bus ();
  hack_cpu_mc_if #(.DW(24), .AW(20)) bus2 ();
  logic [14:0] pc;
  logic        retired, halted;
  logic [19:0] pc2;
  logic        retired2, halted2;

  hack_cpu_mc #(.DW(16), .AW(15)) dut (
    .clk(clk), .reset(reset), .bus(bus), .pc(pc), .retired(retired), .halted(halted));
  hack_cpu_mc #(.DW(24), .AW(20)) dut2 (
    .clk(clk), .reset(reset2), .bus(bus2), .pc(pc2), .retired(retired2), .halted(halted2));

  int checks = 0;
  int failures = 0;

  localparam logic [5:0] C_ZERO = 6'b101010, C_NEG1 = 6'b111010, C_D = 6'b001100;
  localparam logic [5:0] C_A = 6'b110000, C_AP1 = 6'b110111;

  logic [15:0] prog [64];
  logic [15:0] ram  [32768];
  logic [15:0] mram [32768];
  int          ilat, dlat;
  bit          spurious;
  int          wr_cnt, wr_base;
  logic [14:0] w_addr;
  logic [15:0] w_data;
  int          w2_cnt;
  logic [19:0] w2_addr;
  logic [23:0] w2_data;

  // reference machine state
  logic [15:0] mA, mD;
  logic [14:0] mpc;
  bit          mprev, mhalt;
  int          m_wr;
  logic [14:0] m_waddr;
  logic [15:0] m_wdata;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [15:0] ci(input logic a, input logic [5:0] c,
                                     input logic [2:0] d, input logic [2:0] j);
    return {3'b111, a, c, d, j};
  endfunction

  function automatic logic [15:0] imem_rd(input logic [14:0] addr);
    logic [5:0] idx;
    idx = addr[5:0];
    return (addr < 15'd64) ? prog[idx] : 16'h0000;
  endfunction

  function automatic logic [5:0] code_at(input int k);
    case (k)
      0: return 6'b101010;  1: return 6'b111111;  2: return 6'b111010;
      3: return 6'b001100;  4: return 6'b110000;  5: return 6'b001101;
      6: return 6'b110001;  7: return 6'b001111;  8: return 6'b110011;
      9: return 6'b011111; 10: return 6'b110111; 11: return 6'b001110;
      12: return 6'b110010; 13: return 6'b000010; 14: return 6'b010011;
      15: return 6'b000111; 16: return 6'b000000; default: return 6'b010101;
    endcase
  endfunction

  // Hack mnemonic semantics by opcode, independent of the zx/nx/zy/ny/f/no datapath
  function automatic logic [15:0] hack_comp(input logic [5:0] c, input logic [15:0] dv,
                                            input logic [15:0] yv);
    case (c)
      6'b101010: return 16'd0;
      6'b111111: return 16'd1;
      6'b111010: return 16'hFFFF;
      6'b001100: return dv;
      6'b110000: return yv;
      6'b001101: return ~dv;
      6'b110001: return ~yv;
      6'b001111: return 16'd0 - dv;
      6'b110011: return 16'd0 - yv;
      6'b011111: return dv + 16'd1;
      6'b110111: return yv + 16'd1;
      6'b001110: return dv - 16'd1;
      6'b110010: return yv - 16'd1;
      6'b000010: return dv + yv;
      6'b010011: return dv - yv;
      6'b000111: return yv - dv;
      6'b000000: return dv & yv;
      default:   return dv | yv;
    endcase
  endfunction

  function automatic logic [23:0] prog2(input logic [19:0] a);
    case (a)
      20'd0:     return 24'h7FFFFF;
      20'd1:     return {11'h7FF, 1'b0, 6'b110111, 3'b010, 3'b000};
      20'd2:     return 24'h0FFFFF;
      20'd3:     return {11'h7FF, 1'b0, 6'b001100, 3'b000, 3'b100};
      20'hFFFFF: return {11'h7FF, 1'b0, 6'b001100, 3'b001, 3'b000};
      default:   return 24'h000000;
    endcase
  endfunction

  task automatic model_step();
    logic [15:0] ins, y, out;
    logic [14:0] aold;
    bit jmp;
    ins = imem_rd(mpc);
    if (!ins[15]) begin
      mA = ins;
      mpc = mpc + 15'd1;
      mprev = 1'b1;
    end else begin
      aold = mA[14:0];
      y = ins[12] ? mram[aold] : mA;
      out = hack_comp(ins[11:6], mD, y);
      jmp = (ins[2] && $signed(out) < 0) || (ins[1] && out == 16'd0) ||
            (ins[0] && $signed(out) > 0);
      if (ins[3]) begin
        mram[aold] = out;
        m_wr++;
        m_waddr = aold;
        m_wdata = out;
      end
      if (ins[5]) mA = out;
      if (ins[4]) mD = out;
      if (jmp) begin
        mhalt = (aold == mpc) || ((aold == mpc - 15'd1) && mprev);
        mpc = aold;
      end else begin
        mpc = mpc + 15'd1;
      end
      mprev = 1'b0;
    end
  endtask

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic wait_retire(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 300; i++) begin
      step();
      if (retired) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic run_prog(input int max_ret);
    bit ok;
    for (int n = 0; n < max_ret && !mhalt; n++) begin
      wait_retire(ok);
      check("retire_seen", 32'(ok), 32'd1);
      if (!ok) return;
      model_step();
      check("pc", 32'(pc), 32'(mpc));
      check("halted", 32'(halted), 32'(mhalt));
      check("wr_cnt", 32'(wr_cnt - wr_base), 32'(m_wr));
      if (m_wr > 0) begin
        check("wr_addr", 32'(w_addr), 32'(m_waddr));
        check("wr_data", 32'(w_data), 32'(m_wdata));
      end
    end
  endtask

  task automatic model_reset();
    mA = '0; mD = '0; mpc = '0; mprev = 1'b0; mhalt = 1'b0; m_wr = 0;
    wr_base = wr_cnt;
  endtask

  task automatic clear_prog();
    for (int i = 0; i < 64; i++) prog[i] = 16'h0000;
  endtask

  task automatic rand_ram();
    for (int i = 0; i < 32768; i++) mram[i] = 16'($urandom);
  endtask

  task automatic start_prog();
    reset = 1'b1;
    step();
    step();
    for (int i = 0; i < 32768; i++) ram[i] = mram[i];
    model_reset();
    reset = 1'b0;
  endtask

  task automatic check_quiet(input string tag);
    int ev;
    ev = 0;
    for (int i = 0; i < 20; i++) begin
      step();
      if (bus.imem_req || bus.dmem_req || retired) ev++;
    end
    check(tag, 32'(ev), 32'd0);
  endtask

  // instruction memory responder
  initial begin
    bit busy;
    int cnt;
    busy = 1'b0;
    cnt = 0;
    bus.imem_ack = 1'b0;
    bus.imem_rdata = '0;
    forever begin
      @(negedge clk);
      if (bus.imem_req) begin
        if (!busy) begin
          busy = 1'b1;
          cnt = (ilat < 0) ? int'($urandom_range(0, 3)) : ilat;
        end
        if (cnt == 0) begin
          bus.imem_ack = 1'b1;
          bus.imem_rdata = imem_rd(bus.imem_addr);
          busy = 1'b0;
        end else begin
          bus.imem_ack = 1'b0;
          bus.imem_rdata = 16'($urandom);
          cnt--;
        end
      end else begin
        busy = 1'b0;
        bus.imem_ack = spurious && ($urandom_range(0, 3) == 0);
        bus.imem_rdata = 16'($urandom);
      end
    end
  end

  // data memory responder
  initial begin
    bit busy;
    int cnt;
    busy = 1'b0;
    cnt = 0;
    wr_cnt = 0;
    w_addr = '0;
    w_data = '0;
    bus.dmem_ack = 1'b0;
    bus.dmem_rdata = '0;
    forever begin
      @(negedge clk);
      if (bus.dmem_req) begin
        if (!busy) begin
          busy = 1'b1;
          cnt = (dlat < 0) ? int'($urandom_range(0, 3)) : dlat;
        end
        if (cnt == 0) begin
          bus.dmem_ack = 1'b1;
          busy = 1'b0;
          if (bus.dmem_we) begin
            ram[bus.dmem_addr] = bus.dmem_wdata;
            wr_cnt++;
            w_addr = bus.dmem_addr;
            w_data = bus.dmem_wdata;
          end else begin
            bus.dmem_rdata = ram[bus.dmem_addr];
          end
        end else begin
          bus.dmem_ack = 1'b0;
          bus.dmem_rdata = 16'($urandom);
          cnt--;
        end
      end else begin
        busy = 1'b0;
        bus.dmem_ack = spurious && ($urandom_range(0, 3) == 0);
        bus.dmem_rdata = 16'($urandom);
      end
    end
  end

  // zero-wait memories for the wide instance
  initial begin
    w2_cnt = 0;
    w2_addr = '0;
    w2_data = '0;
    bus2.imem_ack = 1'b0;
    bus2.imem_rdata = '0;
    bus2.dmem_ack = 1'b0;
    bus2.dmem_rdata = '0;
    forever begin
      @(negedge clk);
      bus2.imem_ack = bus2.imem_req;
      bus2.imem_rdata = prog2(bus2.imem_addr);
      bus2.dmem_ack = bus2.dmem_req;
      if (bus2.dmem_req && bus2.dmem_we) begin
        w2_cnt++;
        w2_addr = bus2.dmem_addr;
        w2_data = bus2.dmem_wdata;
      end
    end
  end

  initial begin
    #900000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bit ok2;
    reset = 1'b1;
    reset2 = 1'b1;
    ilat = 0;
    dlat = 0;
    spurious = 1'b0;

    // reset state
    step();
    check("rst_pc", 32'(pc), 32'd0);
    check("rst_retired", 32'(retired), 32'd0);
    check("rst_halted", 32'(halted), 32'd0);
    check("rst_imem_req", 32'(bus.imem_req), 32'd0);
    check("rst_dmem_req", 32'(bus.dmem_req), 32'd0);

    // @5; D=A; @0; M=D with zero-wait memories
    clear_prog();
    prog[0] = 16'd5;
    prog[1] = ci(1'b0, C_A, 3'b010, 3'b000);
    prog[2] = 16'd0;
    prog[3] = ci(1'b0, C_D, 3'b001, 3'b000);
    prog[4] = 16'd4;
    prog[5] = ci(1'b0, C_ZERO, 3'b000, 3'b111);
    rand_ram();
    start_prog();
    run_prog(4);
    check("basic_pc", 32'(pc), 32'd4);
    check("basic_ram0", 32'(ram[0]), 32'd5);
    run_prog(20);
    check("basic_halted", 32'(halted), 32'd1);

    // AM=M+1 with slow fetch and slow data acks
    ilat = 3;
    dlat = 2;
    clear_prog();
    prog[0] = 16'd7;
    prog[1] = ci(1'b1, C_AP1, 3'b101, 3'b000);
    prog[2] = ci(1'b0, C_A, 3'b010, 3'b000);
    prog[3] = 16'd0;
    prog[4] = ci(1'b0, C_D, 3'b001, 3'b000);
    prog[5] = 16'd5;
    prog[6] = ci(1'b0, C_ZERO, 3'b000, 3'b111);
    rand_ram();
    mram[7] = 16'd9;
    start_prog();
    run_prog(2);
    check("amm_wr_addr", 32'(w_addr), 32'd7);
    check("amm_wr_data", 32'(w_data), 32'd10);
    run_prog(20);
    check("amm_new_a", 32'(ram[0]), 32'd10);

    // conditional jumps on negative and zero D, then @END; 0;JMP
    ilat = -1;
    dlat = -1;
    spurious = 1'b1;
    clear_prog();
    prog[0]  = ci(1'b0, C_NEG1, 3'b010, 3'b000);
    prog[1]  = 16'd20;
    prog[2]  = ci(1'b0, C_D, 3'b000, 3'b100);
    prog[20] = ci(1'b0, C_ZERO, 3'b010, 3'b000);
    prog[21] = 16'd30;
    prog[22] = ci(1'b0, C_D, 3'b000, 3'b001);
    prog[23] = 16'd23;
    prog[24] = ci(1'b0, C_ZERO, 3'b000, 3'b111);
    rand_ram();
    start_prog();
    run_prog(3);
    check("jlt_pc", 32'(pc), 32'd20);
    run_prog(3);
    check("jgt_pc", 32'(pc), 32'd23);
    run_prog(20);
    check("end_halted", 32'(halted), 32'd1);
    check_quiet("end_quiet");

    // reset while a write waits for its ack
    ilat = 0;
    dlat = 10;
    spurious = 1'b0;
    clear_prog();
    prog[0] = 16'd9;
    prog[1] = ci(1'b0, C_A, 3'b010, 3'b000);
    prog[2] = 16'd4;
    prog[3] = ci(1'b0, C_D, 3'b001, 3'b000);
    rand_ram();
    start_prog();
    ok2 = 1'b0;
    for (int i = 0; i < 100; i++) begin
      step();
      if (bus.dmem_req && bus.dmem_we) begin
        ok2 = 1'b1;
        break;
      end
    end
    check("memwr_reached", 32'(ok2), 32'd1);
    reset = 1'b1;
    #1;
    check("rstwr_dmem_req", 32'(bus.dmem_req), 32'd0);
    step();
    check("rstwr_pc", 32'(pc), 32'd0);
    check("rstwr_no_write", 32'(wr_cnt - wr_base), 32'd0);
    dlat = 0;
    clear_prog();
    prog[0] = ci(1'b0, C_D, 3'b001, 3'b000);
    prog[1] = 16'd1;
    prog[2] = ci(1'b0, C_ZERO, 3'b000, 3'b111);
    model_reset();
    reset = 1'b0;
    #1;
    check("restart_req", 32'(bus.imem_req), 32'd1);
    check("restart_addr", 32'(bus.imem_addr), 32'd0);
    run_prog(10);
    check("restart_halted", 32'(halted), 32'd1);

    // random programs with random latencies and stray acks
    ilat = -1;
    dlat = -1;
    spurious = 1'b1;
    for (int p = 0; p < 5; p++) begin
      for (int i = 0; i < 64; i++) begin
        if ($urandom_range(0, 2) == 0)
          prog[i] = {1'b0, 15'($urandom_range(0, 63))};
        else
          prog[i] = ci(1'($urandom_range(0, 1)), code_at(int'($urandom_range(0, 17))),
                       3'($urandom_range(0, 7)),
                       ($urandom_range(0, 3) == 0) ? 3'($urandom_range(1, 7)) : 3'b000);
      end
      rand_ram();
      start_prog();
      run_prog(150);
    end
    reset = 1'b1;

    // 24-bit data, 20-bit pc: ng from 0x7FFFFF+1 and pc wrap
    reset2 = 1'b0;
    for (int i = 0; i < 5; i++) begin
      ok2 = 1'b0;
      for (int c = 0; c < 50; c++) begin
        step();
        if (retired2) begin
          ok2 = 1'b1;
          break;
        end
      end
      check("wide_retire_seen", 32'(ok2), 32'd1);
      if (i == 3) begin
        check("wide_jlt_pc", 32'(pc2), 32'hFFFFF);
        check("wide_not_halted", 32'(halted2), 32'd0);
      end
    end
    check("wide_pc_wrap", 32'(pc2), 32'd0);
    check("wide_wr_cnt", 32'(w2_cnt), 32'd1);
    check("wide_wr_addr", 32'(w2_addr), 32'hFFFFF);
    check("wide_wr_data", 32'(w2_data), 32'h800000);
    reset2 = 1'b1;
    step();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
